// File: rtl/ysyx_24070003_muldiv.sv
// ysyx_24070003_muldiv
//   Iterative RV32M/RV64M-style multiply/divide unit. A request is taken in
//   IDLE, iterated for XLEN cycles in CALC (radix-2 shift-add multiply or
//   radix-2 restoring divide on operand magnitudes), and its result is held
//   in DONE until the consumer handshakes. Divide-by-zero and signed
//   overflow skip CALC and complete one cycle after acceptance.
//
// Ports
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   : request handshake (in_ready only in IDLE)
//   op                    : 000 MUL 001 MULH 010 MULHSU 011 MULHU
//                           100 DIV 101 DIVU 110 REM 111 REMU
//   opdata1, opdata2      : rs1 (multiplicand/dividend), rs2 (multiplier/divisor)
//   flush                 : abandon any in-flight operation, return to IDLE
//   out_valid / out_ready : result handshake (out_valid only in DONE)
//   result                : registered operation result
module ysyx_24070003_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opdata1,
    input  logic [XLEN-1:0] opdata2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  count;
    logic [2*XLEN-1:0] acc;        // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [2*XLEN-1:0] acc_next;
    logic [XLEN-1:0]   opb;        // mul: multiplicand magnitude; div: divisor magnitude
    logic              is_div;
    logic              sel_high;
    logic              sel_rem;
    logic              neg_main;   // product / quotient sign
    logic              neg_rem;    // remainder follows the dividend sign

    logic              accept;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic              div_zero, div_ovf, bypass;
    logic [XLEN-1:0]   a_mag, b_mag, bypass_result, final_result;
    logic [XLEN:0]     mul_sum, trial, diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem;

    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg_wide(input logic [2*XLEN-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready && !flush;

    // Request decode: signedness per operand, magnitudes, special divide cases.
    always_comb begin
        a_signed = op[2] ? ~op[0] : (op[1:0] != 2'b11);
        b_signed = op[2] ? ~op[0] : ~op[1];
        a_neg    = a_signed & opdata1[XLEN-1];
        b_neg    = b_signed & opdata2[XLEN-1];
        a_mag    = cneg(opdata1, a_neg);
        b_mag    = cneg(opdata2, b_neg);
        div_zero = op[2] && (opdata2 == '0);
        div_ovf  = op[2] && !op[0] && (opdata1 == MIN_INT) && (opdata2 == '1);
        bypass   = div_zero || div_ovf;
        if (div_zero) begin
            bypass_result = op[1] ? opdata1 : '1;
        end else begin
            bypass_result = op[1] ? '0 : opdata1;
        end
    end

    // One radix-2 iteration. The multiply adds into the upper half with a
    // carry bit and shifts right; the divide shifts the next dividend bit
    // into the remainder and keeps the difference when it does not borrow.
    always_comb begin
        acc_next = acc;
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
        trial    = acc[2*XLEN-1:XLEN-1];
        diff     = trial - {1'b0, opb};
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc[2*XLEN-2:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_next = {mul_sum, acc[XLEN-1:1]};
            end else begin
                acc_next = {1'b0, acc[2*XLEN-1:1]};
            end
        end
    end

    // Sign fix-up and result selection from the final iteration's value.
    always_comb begin
        prod = cneg_wide(acc_next, neg_main);
        quot = cneg(acc_next[XLEN-1:0], neg_main);
        rem  = cneg(acc_next[2*XLEN-1:XLEN], neg_rem);
        if (is_div) begin
            final_result = sel_rem ? rem : quot;
        end else begin
            final_result = sel_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = bypass ? DONE : CALC;
            CALC:    if (count == LAST_ITER) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            result <= '0;
        end else begin
            state <= state_next;
            if ((state == CALC) && !flush && (count != LAST_ITER)) begin
                count <= count + CNT_W'(1);
            end else begin
                count <= '0;
            end
            if (accept && bypass) begin
                result <= bypass_result;
            end else if ((state == CALC) && (count == LAST_ITER) && !flush) begin
                result <= final_result;
            end
        end
    end

    // Operand/iteration datapath; only meaningful between accept and DONE,
    // so it carries no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            acc      <= {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
            opb      <= op[2] ? b_mag : a_mag;
            is_div   <= op[2];
            sel_high <= (op[1:0] != 2'b00);
            sel_rem  <= op[1];
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
        end else if (state == CALC) begin
            acc <= acc_next;
        end
    end

endmodule

// File: tb/tb_ysyx_24070003_muldiv.sv
// Testbench for ysyx_24070003_muldiv (XLEN=32): directed vectors, backpressure,
// flush and reset cases, then randomized requests scored against a plain
// 64-bit arithmetic reference model through an expectation queue.
module tb_ysyx_24070003_muldiv;

    localparam int XLEN = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  op = 3'd0;
    logic [31:0] opdata1 = 32'd0;
    logic [31:0] opdata2 = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;

    ysyx_24070003_muldiv #(.XLEN(32), .CNT_W(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .opdata1   (opdata1),
        .opdata2   (opdata2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        int          cyc;
        logic [2:0]  op;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    int          rdy_mode = 0;
    bit          noise_all = 1'b0;
    bit          in_txn = 1'b0;
    logic [31:0] held = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sbv, p;
        longint unsigned ua, ub, pu;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        case (o)
            3'd0: begin p = sa * sbv; return p[31:0]; end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin pu = ua * ub; return pu[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return a;
                p = sa / sbv; return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sbv; return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 32'd0 || (!o[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
        return XLEN + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MINV;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Waits for in_ready (pulsing garbage in_valid while busy), issues one
    // request and records its expectation with the cycle of first out_valid.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expv, input int lat, input bit push, output int t);
        int guard = 0;
        t = -1;
        while (in_ready !== 1'b1) begin
            @(negedge clock);
            if (in_ready !== 1'b1) begin
                in_valid = noise_all ? 1'b1 : 1'($urandom_range(0, 1));
                op       = 3'($urandom);
                opdata1  = $urandom;
                opdata2  = $urandom;
            end
            guard++;
            if (guard > 500) begin
                checks++;
                failures++;
                $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        op       = o;
        opdata1  = a;
        opdata2  = b;
        in_valid = 1'b1;
        t        = cyc;
        if (push) exp_q.push_back('{expv, cyc + lat, o});
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        op       = 3'($urandom);
        opdata1  = $urandom;
        opdata2  = $urandom;
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && g < 300) begin
            @(negedge clock);
            g++;
        end
        if (g >= 300) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
        end
    endtask

    // Consumer ready generator.
    initial begin
        int vcnt = 0;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid === 1'b1) vcnt++;
                    else vcnt = 0;
                    out_ready = (vcnt >= 4);
                end
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: latency on first out_valid, stability while held, value on handshake.
    always @(negedge clock) begin
        if (out_valid === 1'b1) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                held   = result;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out_valid actual=%h required=no_output", result);
                end else if (cyc != exp_q[0].cyc) begin
                    failures++;
                    $display("FAIL latency_op%0d actual_cycle=%0d required_cycle=%0d",
                             exp_q[0].op, cyc, exp_q[0].cyc);
                end
            end else begin
                check("hold_stable", result, held);
            end
            if (out_ready === 1'b1) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check($sformatf("result_op%0d", e.op), result, e.val);
                end
                in_txn = 1'b0;
            end
        end else begin
            in_txn = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;

        // First accept on the very first edge with reset low.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1, t);
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1, t);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b1, t);
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1'b1, t);
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b1, t);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b1, t);
        issue(3'd5, 32'd100, 32'd7, 32'd14, 33, 1'b1, t);
        issue(3'd7, 32'd100, 32'd7, 32'd2, 33, 1'b1, t);
        issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, t);
        issue(3'd7, 32'd5, 32'd0, 32'd5, 1, 1'b1, t);
        issue(3'd4, MINV, 32'hFFFF_FFFF, MINV, 1, 1'b1, t);
        issue(3'd6, MINV, 32'hFFFF_FFFF, 32'd0, 1, 1'b1, t);
        issue(3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 1'b1, t);
        drain();

        // Backpressure: out_ready low three cycles, in_valid pulsed while busy.
        rdy_mode  = 2;
        noise_all = 1'b1;
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1, t);
        issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, t);
        issue(3'd7, 32'd100, 32'd7, 32'd2, 33, 1'b1, t);
        drain();
        noise_all = 1'b0;
        rdy_mode  = 0;
        in_valid  = 1'b0;

        // Flush in CALC.
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 0, 1'b0, t);
        while (cyc < t + 10) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        check("flush_calc_in_ready", 32'(in_ready), 32'd1);
        check("flush_calc_out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        issue(3'd0, 32'd3, 32'd4, 32'd12, 33, 1'b1, t);
        drain();

        // Flush while a result waits in DONE.
        rdy_mode = 3;
        @(negedge clock);
        @(negedge clock);
        issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, t);
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        check("flush_done_out_valid", 32'(out_valid), 32'd0);
        check("flush_done_in_ready", 32'(in_ready), 32'd1);
        flush = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        rdy_mode = 0;
        @(negedge clock);

        // Asynchronous reset in the middle of CALC.
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0, 1'b0, t);
        while (cyc < t + 5) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_result", result, 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        #1;
        reset = 1'b0;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b1, t);
        drain();

        // Randomized requests with random backpressure and busy-time noise.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom);
            ra = pick();
            rb = pick();
            issue(ro, ra, rb, ref_model(ro, ra, rb), ref_lat(ro, ra, rb), 1'b1, t);
        end
        drain();
        rdy_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
